// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_pkg
//  Purpose  : Shared BCD constants and helpers for the clock/timer datapath.
//  Revision : 1.0  initial release
// ============================================================================
package clock_pkg;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_MAX        = 9;
  localparam int BCD_MAX_DIGITS = 4;

  // Convert a non-negative integer to packed BCD, digit 0 in bits [3:0].
  function automatic logic [15:0] int_to_bcd(input int value);
    int          v;
    logic [15:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // True when each of the low 'digits' nibbles holds a decimal digit.
  function automatic logic bcd_is_valid(input logic [15:0] value, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits && value[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'(BCD_MAX)) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter_mod_digit.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit
//  Purpose  : One combinational BCD digit stage: increments or decrements a
//             digit when enabled and flags the roll-over to the next stage.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_digit
  import clock_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  input  logic                   up,
  input  logic                   cin,
  output logic [BCD_DIGIT_W-1:0] next_digit,
  output logic                   cout
);

  // Step the digit up (9 -> 0) or down (0 -> 9), rolling out on wrap.
  always_comb begin
    next_digit = digit;
    cout       = 1'b0;
    if (cin) begin
      if (up) begin
        if (digit >= 4'(BCD_MAX)) begin
          next_digit = '0;
          cout       = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end else begin
        if (digit == '0) begin
          next_digit = 4'(BCD_MAX);
          cout       = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_counter_mod.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_counter_mod
//  Purpose  : Parametrised up/down BCD modulo counter with clear, validated
//             load and registered carry/borrow/load-error pulses.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_counter_mod
  import clock_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clk_time,
  input  logic                        up_down,
  input  logic                        clear,
  input  logic                        load,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] load_bcd,
  output logic [BCD_DIGIT_W*DIGITS-1:0] count_bcd,
  output logic                        carry,
  output logic                        borrow,
  output logic                        at_zero,
  output logic                        load_err
);

  localparam int W = BCD_DIGIT_W * DIGITS;

  // Largest count value as a BCD constant; upper digits are zero because
  // MODULUS-1 always fits in DIGITS decimal digits.
  localparam logic [15:0]  c_max_full = int_to_bcd(MODULUS - 1);
  localparam logic [W-1:0] c_max_bcd  = c_max_full[W-1:0];

  if (DIGITS < 1 || DIGITS > BCD_MAX_DIGITS ||
      MODULUS < 2 || MODULUS > 10**DIGITS) begin : g_param_error
    $error("bcd_counter_mod: illegal DIGITS=%0d / MODULUS=%0d", DIGITS, MODULUS);
  end

  logic [W-1:0]    r_count;
  logic            r_carry;
  logic            r_borrow;
  logic            r_load_err;
  logic [W-1:0]    w_step;
  logic [DIGITS:0] w_cin;
  logic [15:0]     w_load_ext;
  logic            w_load_ok;
  logic            w_wrap;

  // The ripple chain is always enabled; its result is used only on a tick.
  assign w_cin[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .digit      (r_count[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .up         (up_down),
      .cin        (w_cin[i]),
      .next_digit (w_step[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .cout       (w_cin[i+1])
    );
  end

  // Widen the load value so it can be compared with the 4-digit constant.
  always_comb begin
    w_load_ext        = '0;
    w_load_ext[W-1:0] = load_bcd;
  end

  // For valid BCD the binary ordering equals the decimal ordering, so a
  // direct compare against MODULUS-1 checks the range.
  assign w_load_ok = bcd_is_valid(w_load_ext, DIGITS) && (w_load_ext <= c_max_full);

  // Up wraps at MODULUS-1 (the top-digit roll-out covers MODULUS = 10^DIGITS);
  // down wraps exactly when the borrow ripples out of the top digit, i.e. at 0.
  assign w_wrap = up_down ? ((r_count == c_max_bcd) | w_cin[DIGITS]) : w_cin[DIGITS];

  // Count register and one-cycle status pulses; clear > load > tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
      if (clear) begin
        r_count <= '0;
      end else if (load) begin
        if (w_load_ok) begin
          r_count <= load_bcd;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (clk_time) begin
        if (w_wrap) begin
          if (up_down) begin
            r_count <= '0;
            r_carry <= 1'b1;
          end else begin
            r_count  <= c_max_bcd;
            r_borrow <= 1'b1;
          end
        end else begin
          r_count <= w_step;
        end
      end
    end
  end

  assign count_bcd = r_count;
  assign carry     = r_carry;
  assign borrow    = r_borrow;
  assign load_err  = r_load_err;
  assign at_zero   = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_mod.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_counter_mod
//  Purpose  : Scoreboard bench driving mod-60, mod-1000 and mod-24 counters
//             from one shared stimulus stream against an integer model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_counter_mod;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear, load, clk_time, up_down;
  logic [11:0] load_bcd;

  logic [7:0]  cnt60, cnt24;
  logic [11:0] cnt1000;
  logic [2:0]  carry_o, borrow_o, zero_o, err_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          dut;
    logic [11:0] cnt;
    logic        carry;
    logic        borrow;
    logic        err;
    logic        zero;
  } exp_t;

  exp_t sb_q[$];
  int   m_cnt[3];
  int   c_mod[3] = '{60, 1000, 24};

  always #5 clk = ~clk;

  bcd_counter_mod #(.DIGITS(2), .MODULUS(60)) u_d60 (
    .clk(clk), .reset_n(reset_n), .clk_time(clk_time), .up_down(up_down),
    .clear(clear), .load(load), .load_bcd(load_bcd[7:0]), .count_bcd(cnt60),
    .carry(carry_o[0]), .borrow(borrow_o[0]), .at_zero(zero_o[0]), .load_err(err_o[0])
  );

  bcd_counter_mod #(.DIGITS(3), .MODULUS(1000)) u_d1000 (
    .clk(clk), .reset_n(reset_n), .clk_time(clk_time), .up_down(up_down),
    .clear(clear), .load(load), .load_bcd(load_bcd), .count_bcd(cnt1000),
    .carry(carry_o[1]), .borrow(borrow_o[1]), .at_zero(zero_o[1]), .load_err(err_o[1])
  );

  bcd_counter_mod #(.DIGITS(2), .MODULUS(24)) u_d24 (
    .clk(clk), .reset_n(reset_n), .clk_time(clk_time), .up_down(up_down),
    .clear(clear), .load(load), .load_bcd(load_bcd[7:0]), .count_bcd(cnt24),
    .carry(carry_o[2]), .borrow(borrow_o[2]), .at_zero(zero_o[2]), .load_err(err_o[2])
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic int bcd_val(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [11:0] dut_count(input int d);
    if (d == 0) return {4'h0, cnt60};
    if (d == 1) return cnt1000;
    return {4'h0, cnt24};
  endfunction

  // Reference behaviour in plain integer arithmetic for one counter.
  task automatic model_step(input int d);
    exp_t        e;
    logic [11:0] raw;
    logic        ok;
    e.dut    = d;
    e.carry  = 1'b0;
    e.borrow = 1'b0;
    e.err    = 1'b0;
    raw = load_bcd & ((d == 1) ? 12'hFFF : 12'h0FF);
    if (clear) begin
      m_cnt[d] = 0;
    end else if (load) begin
      ok = 1'b1;
      for (int i = 0; i < 3; i++) if (raw[i*4 +: 4] > 4'd9) ok = 1'b0;
      if (ok && bcd_val(raw) < c_mod[d]) m_cnt[d] = bcd_val(raw);
      else e.err = 1'b1;
    end else if (clk_time) begin
      if (up_down) begin
        if (m_cnt[d] == c_mod[d] - 1) begin m_cnt[d] = 0; e.carry = 1'b1; end
        else m_cnt[d] = m_cnt[d] + 1;
      end else begin
        if (m_cnt[d] == 0) begin m_cnt[d] = c_mod[d] - 1; e.borrow = 1'b1; end
        else m_cnt[d] = m_cnt[d] - 1;
      end
    end
    e.cnt  = to_bcd(m_cnt[d]);
    e.zero = (m_cnt[d] == 0);
    sb_q.push_back(e);
  endtask

  // Drive one cycle, record expectations, then compare after the edge.
  task automatic cycle(input logic c, input logic l, input logic [11:0] v,
                       input logic t, input logic u);
    exp_t e;
    clear = c; load = l; load_bcd = v; clk_time = t; up_down = u;
    for (int d = 0; d < 3; d++) model_step(d);
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_value($sformatf("mod%0d count", c_mod[e.dut]), 32'(dut_count(e.dut)), 32'(e.cnt));
      check_value($sformatf("mod%0d carry", c_mod[e.dut]), 32'(carry_o[e.dut]), 32'(e.carry));
      check_value($sformatf("mod%0d borrow", c_mod[e.dut]), 32'(borrow_o[e.dut]), 32'(e.borrow));
      check_value($sformatf("mod%0d load_err", c_mod[e.dut]), 32'(err_o[e.dut]), 32'(e.err));
      check_value($sformatf("mod%0d at_zero", c_mod[e.dut]), 32'(zero_o[e.dut]), 32'(e.zero));
    end
    clear = 1'b0; load = 1'b0; clk_time = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      check_value($sformatf("%s mod%0d count", tag, c_mod[d]), 32'(dut_count(d)), 32'h0);
      check_value($sformatf("%s mod%0d carry", tag, c_mod[d]), 32'(carry_o[d]), 32'h0);
      check_value($sformatf("%s mod%0d borrow", tag, c_mod[d]), 32'(borrow_o[d]), 32'h0);
      check_value($sformatf("%s mod%0d load_err", tag, c_mod[d]), 32'(err_o[d]), 32'h0);
      check_value($sformatf("%s mod%0d at_zero", tag, c_mod[d]), 32'(zero_o[d]), 32'h1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    clk_time = 1'b0;
    up_down  = 1'b1;
    load_bcd = '0;
    m_cnt    = '{0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    #3 reset_n = 1'b1;

    // Up through the mod-60 wrap
    cycle(0, 1, 12'h058, 0, 1);
    cycle(0, 0, 12'h000, 1, 1);
    cycle(0, 0, 12'h000, 1, 1);
    cycle(0, 0, 12'h000, 0, 1);

    // Down from zero
    cycle(1, 0, 12'h000, 0, 0);
    cycle(0, 0, 12'h000, 1, 0);
    cycle(0, 0, 12'h000, 1, 0);

    // Load validation
    cycle(0, 1, 12'h07A, 0, 1);
    cycle(0, 1, 12'h072, 0, 1);
    cycle(0, 1, 12'h045, 0, 1);

    // Priority
    cycle(1, 1, 12'h030, 1, 1);
    cycle(0, 1, 12'h030, 1, 1);

    // Three-digit full-range wrap, then mod-24 wrap and digit roll
    cycle(0, 1, 12'h999, 0, 1);
    cycle(0, 0, 12'h000, 1, 1);
    cycle(0, 1, 12'h023, 0, 1);
    cycle(0, 0, 12'h000, 1, 1);
    cycle(0, 1, 12'h009, 0, 1);
    cycle(0, 0, 12'h000, 1, 1);

    // Mixed random traffic, back-to-back ticks included
    for (int k = 0; k < 40; k++) begin
      cycle(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 5) == 0),
            12'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
    end

    // Reach mod-60 = 0x37 with a mod-24 carry pulse showing, then reset mid-cycle
    cycle(0, 1, 12'h023, 0, 1);
    cycle(0, 1, 12'h036, 0, 1);
    cycle(0, 0, 12'h000, 1, 1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    m_cnt = '{0, 0, 0};
    #1 reset_n = 1'b1;
    cycle(0, 0, 12'h000, 1, 1);
    cycle(0, 0, 12'h000, 1, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
